// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: direction-counter encoding, BTB entry
// layout and the saturating counter steps used on update.
package bp_pkg;

  localparam int BP_ADDR_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Tag and target are held at full address width; the top only ever writes
  // zero-extended PC_W-bit values into them.
  typedef struct packed {
    logic                 valid;
    logic [BP_ADDR_W-1:0] tag;
    logic [BP_ADDR_W-1:0] target;
    logic                 is_jump;
    ctr_e                 ctr;
  } bp_entry_t;

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: one combinational lookup port and one
// read-modify-write update port, cleared by synchronous reset.
module bp_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     rd_idx,
  output bp_entry_t            rd_entry,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [BP_ADDR_W-1:0] wr_tag,
  input  logic [BP_ADDR_W-1:0] wr_target,
  input  logic                 wr_branch,
  input  logic                 wr_taken
);

  localparam int N = 1 << IDX_W;

  bp_entry_t mem [N];
  bp_entry_t cur;
  bp_entry_t nxt;
  logic      hit;

  // Lookup reads the registered array, so a same-cycle update is not seen.
  assign rd_entry = mem[rd_idx];

  always_comb begin
    cur = mem[wr_idx];
    hit = cur.valid && (cur.tag == wr_tag);
    nxt = cur;
    if (hit) begin
      if (wr_branch) begin
        nxt.ctr = wr_taken ? ctr_inc(cur.ctr) : ctr_dec(cur.ctr);
        if (wr_taken) nxt.target = wr_target;
      end else begin
        nxt.target = wr_target;
        nxt.ctr    = ST;
      end
    end else if (wr_taken) begin
      nxt.valid   = 1'b1;
      nxt.tag     = wr_tag;
      nxt.target  = wr_target;
      nxt.is_jump = !wr_branch;
      nxt.ctr     = wr_branch ? WT : ST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, is_jump: 1'b0, ctr: WNT};
      end
    end else if (wr_en) begin
      mem[wr_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side BTB lookup plus EX-stage branch/JAL/JALR resolution, redirecting
// only on misprediction, with saturating branch and mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  IfPC,
  output logic             PredTaken,
  output logic [PC_W-1:0]  PredTarget,
  input  logic             ExValid,
  input  logic [PC_W-1:0]  ExPC,
  input  logic             ExBranch,
  input  logic             ExJal,
  input  logic             ExJalr,
  input  logic             ExCond,
  input  logic [31:0]      ExImm,
  input  logic [31:0]      ExReg1,
  input  logic             ExPredTaken,
  input  logic [PC_W-1:0]  ExPredTarget,
  output logic [31:0]      PC_Four,
  output logic [31:0]      PC_Imm,
  output logic             Redirect,
  output logic [31:0]      RedirectPC,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] MispCount
);

  localparam int TAG_SH = IDX_W + 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Fetch lookup
  logic [IDX_W-1:0]     if_idx;
  logic [BP_ADDR_W-1:0] if_tag;
  bp_entry_t            if_entry;
  logic                 if_hit;

  assign if_idx     = IfPC[IDX_W+1:2];
  assign if_tag     = BP_ADDR_W'(IfPC >> TAG_SH);
  assign if_hit     = if_entry.valid && (if_entry.tag == if_tag);
  assign PredTaken  = if_hit && (if_entry.is_jump || (if_entry.ctr >= WT));
  assign PredTarget = PredTaken ? PC_W'(if_entry.target) : '0;

  // EX resolve
  logic [31:0] ex_pc_ext;
  logic        is_ctrl;
  logic        act_taken;

  assign ex_pc_ext = 32'(ExPC);
  assign is_ctrl   = ExValid && (ExBranch || ExJal || ExJalr);
  assign act_taken = ExJal || ExJalr || (ExBranch && ExCond);
  assign PC_Four   = ex_pc_ext + 32'd4;
  assign PC_Imm    = ExJalr ? ((ExReg1 + ExImm) & ~32'd1) : (ex_pc_ext + ExImm);

  // Target match uses PC_W bits only, matching what the pipe carries.
  assign Redirect   = is_ctrl && ((act_taken != ExPredTaken) ||
                                  (act_taken && (PC_Imm[PC_W-1:0] != ExPredTarget)));
  assign RedirectPC = !is_ctrl ? '0 : (act_taken ? PC_Imm : PC_Four);

  bp_table #(
    .IDX_W(IDX_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_idx),
    .rd_entry (if_entry),
    .wr_en    (is_ctrl),
    .wr_idx   (ExPC[IDX_W+1:2]),
    .wr_tag   (BP_ADDR_W'(ExPC >> TAG_SH)),
    .wr_target(BP_ADDR_W'(PC_Imm[PC_W-1:0])),
    .wr_branch(ExBranch),
    .wr_taken (act_taken)
  );

  // Performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      BrCount   <= '0;
      MispCount <= '0;
    end else if (is_ctrl) begin
      BrCount <= sat_inc(BrCount);
      if (Redirect) MispCount <= sat_inc(MispCount);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed sequences, a vector table and random
// traffic, all checked against a table-level reference model.
module tb_branch_predictor;

  localparam int PC_W    = 9;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 6;
  localparam int NENT    = 16;
  localparam int PC_MOD  = 512;
  localparam int CNT_MAX = 63;

  logic             clk = 1'b0;
  logic             reset;
  logic [PC_W-1:0]  IfPC;
  logic             PredTaken;
  logic [PC_W-1:0]  PredTarget;
  logic             ExValid;
  logic [PC_W-1:0]  ExPC;
  logic             ExBranch, ExJal, ExJalr, ExCond;
  logic [31:0]      ExImm, ExReg1;
  logic             ExPredTaken;
  logic [PC_W-1:0]  ExPredTarget;
  logic [31:0]      PC_Four, PC_Imm, RedirectPC;
  logic             Redirect;
  logic [CNT_W-1:0] BrCount, MispCount;

  branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .IfPC(IfPC), .PredTaken(PredTaken), .PredTarget(PredTarget),
    .ExValid(ExValid), .ExPC(ExPC), .ExBranch(ExBranch), .ExJal(ExJal), .ExJalr(ExJalr),
    .ExCond(ExCond), .ExImm(ExImm), .ExReg1(ExReg1), .ExPredTaken(ExPredTaken),
    .ExPredTarget(ExPredTarget), .PC_Four(PC_Four), .PC_Imm(PC_Imm), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .BrCount(BrCount), .MispCount(MispCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: BTB as plain arrays, counters as integers.
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  int unsigned m_tgt   [NENT];
  bit          m_jump  [NENT];
  int          m_ctr   [NENT];
  int          m_br, m_misp;

  function automatic void m_clear();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_jump[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0;
    m_misp = 0;
  endfunction

  function automatic void m_pred(input int unsigned pc, output bit t, output int unsigned tgt);
    int unsigned i;
    bit hit;
    i   = (pc / 4) % NENT;
    hit = m_valid[i] && (m_tag[i] == pc / (4 * NENT));
    t   = hit && (m_jump[i] || m_ctr[i] >= 2);
    tgt = t ? m_tgt[i] : 0;
  endfunction

  function automatic bit m_ctrl();
    return ExValid && (ExBranch || ExJal || ExJalr);
  endfunction

  function automatic bit m_act();
    return ExJal || ExJalr || (ExBranch && ExCond);
  endfunction

  function automatic int unsigned m_pcimm();
    if (ExJalr) return (ExReg1 + ExImm) & 32'hFFFF_FFFE;
    return 32'(ExPC) + ExImm;
  endfunction

  function automatic bit m_redirect();
    int unsigned tg;
    tg = m_pcimm() % PC_MOD;
    return m_ctrl() && ((m_act() != ExPredTaken) || (m_act() && tg != 32'(ExPredTarget)));
  endfunction

  task automatic m_check();
    bit t;
    int unsigned tg;
    int unsigned rpc;
    m_pred(32'(IfPC), t, tg);
    rpc = !m_ctrl() ? 0 : (m_act() ? m_pcimm() : 32'(ExPC) + 4);
    chk("model_pred_taken", 32'(PredTaken), 32'(t));
    chk("model_pred_target", 32'(PredTarget), tg);
    chk("model_redirect", 32'(Redirect), 32'(m_redirect()));
    chk("model_redirect_pc", RedirectPC, rpc);
    chk("model_pc_four", PC_Four, 32'(ExPC) + 4);
    if (m_ctrl()) chk("model_pc_imm", PC_Imm, m_pcimm());
    chk("model_br_count", 32'(BrCount), 32'(m_br));
    chk("model_misp_count", 32'(MispCount), 32'(m_misp));
  endtask

  task automatic m_update();
    int unsigned pc, i, tag, tg;
    bit hit, red, act;
    if (reset) begin
      m_clear();
      return;
    end
    if (!m_ctrl()) return;
    pc  = 32'(ExPC);
    i   = (pc / 4) % NENT;
    tag = pc / (4 * NENT);
    tg  = m_pcimm() % PC_MOD;
    act = m_act();
    red = m_redirect();
    hit = m_valid[i] && (m_tag[i] == tag);
    if (hit) begin
      if (ExBranch) begin
        if (act) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = tg;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else begin
        m_tgt[i] = tg;
        m_ctr[i] = 3;
      end
    end else if (act) begin
      m_valid[i] = 1; m_tag[i] = tag; m_tgt[i] = tg;
      m_jump[i] = !ExBranch;
      m_ctr[i] = ExBranch ? 2 : 3;
    end
    m_br = (m_br == CNT_MAX) ? CNT_MAX : m_br + 1;
    if (red) m_misp = (m_misp == CNT_MAX) ? CNT_MAX : m_misp + 1;
  endtask

  task automatic settle();
    #2;
    m_check();
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  // cls: 0 idle, 1 branch, 2 JAL, 3 JALR, 4 valid non-control
  task automatic set_ex(input int cls, input int unsigned pc, input bit cond,
                        input int unsigned imm, input int unsigned reg1,
                        input bit pt, input int unsigned ptgt);
    ExValid      = (cls != 0);
    ExBranch     = (cls == 1);
    ExJal        = (cls == 2);
    ExJalr       = (cls == 3);
    ExPC         = pc[PC_W-1:0];
    ExCond       = cond;
    ExImm        = imm;
    ExReg1       = reg1;
    ExPredTaken  = pt;
    ExPredTarget = ptgt[PC_W-1:0];
  endtask

  typedef struct {
    int          cls;
    int unsigned pc;
    bit          cond;
    int unsigned imm;
    int unsigned reg1;
    bit          pt;
    int unsigned ptgt;
    int unsigned e_pcimm;
    bit          e_red;
    int unsigned e_rpc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 'h040, 1, 'h20, 0, 1, 'h60, 'h60, 0, 'h0};
    vecs[1] = '{4, 'h040, 1, 'h20, 0, 1, 'h60, 'h60, 0, 'h0};
    vecs[2] = '{1, 'h010, 0, 'h8, 0, 0, 'h0, 'h18, 0, 'h14};
    vecs[3] = '{1, 'h100, 1, 'hFFFF_FFF0, 0, 1, 'hF0, 'hF0, 0, 'hF0};
    vecs[4] = '{1, 'h1F0, 1, 'h20, 0, 1, 'h010, 'h210, 0, 'h210};
    vecs[5] = '{2, 'h020, 0, 'h100, 0, 0, 'h0, 'h120, 1, 'h120};
    vecs[6] = '{3, 'h030, 0, 'h21, 'hFFFF_FFF0, 1, 'h10, 'h10, 0, 'h10};
    vecs[7] = '{1, 'h050, 0, 'h40, 0, 1, 'h90, 'h90, 1, 'h54};
    vecs[8] = '{3, 'h060, 1, 'h4, 'h200, 1, 'h004, 'h204, 0, 'h204};
    vecs[9] = '{1, 'h070, 1, 'h10, 0, 1, 'h84, 'h80, 1, 'h80};

    reset = 1'b1;
    IfPC  = '0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    m_clear();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    IfPC = 9'h040;
    settle();
    chk("rst_pred_taken", 32'(PredTaken), 0);
    chk("rst_pred_target", 32'(PredTarget), 0);
    chk("rst_br_count", 32'(BrCount), 0);
    chk("rst_misp_count", 32'(MispCount), 0);
    tick();

    set_ex(1, 'h40, 1, 'h20, 0, 0, 0);
    settle();
    chk("first_br_redirect", 32'(Redirect), 1);
    chk("first_br_redirect_pc", RedirectPC, 32'h60);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("first_br_misp_count", 32'(MispCount), 1);
    chk("first_br_pred_taken", 32'(PredTaken), 1);
    chk("first_br_pred_target", 32'(PredTarget), 32'h60);
    tick();

    for (int k = 0; k < 3; k++) begin
      set_ex(1, 'h40, 1, 'h20, 0, 1, 'h60);
      settle();
      chk("taken_again_redirect", 32'(Redirect), 0);
      tick();
    end
    set_ex(1, 'h40, 0, 'h20, 0, 1, 'h60);
    settle();
    chk("nt_redirect", 32'(Redirect), 1);
    chk("nt_redirect_pc", RedirectPC, 32'h44);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("pred_after_one_nt", 32'(PredTaken), 1);
    tick();
    set_ex(1, 'h40, 0, 'h20, 0, 1, 'h60);
    settle();
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("pred_after_two_nt", 32'(PredTaken), 0);
    tick();

    set_ex(3, 'h1C0, 0, 'h10, 'h101, 1, 'h110);
    settle();
    chk("jalr_pc_imm", PC_Imm, 32'h110);
    chk("jalr_good_redirect", 32'(Redirect), 0);
    tick();
    set_ex(3, 'h1C0, 0, 'h10, 'h101, 1, 'h100);
    settle();
    chk("jalr_bad_redirect", 32'(Redirect), 1);
    chk("jalr_bad_redirect_pc", RedirectPC, 32'h110);
    tick();

    set_ex(1, 'h40, 1, 'h20, 0, 0, 0);
    settle();
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    IfPC = 9'h040;
    settle();
    chk("alias_before_pred", 32'(PredTaken), 1);
    tick();
    set_ex(1, 'h140, 1, 'h8, 0, 0, 0);
    settle();
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("alias_evicted_pred", 32'(PredTaken), 0);
    tick();
    IfPC = 9'h140;
    settle();
    chk("alias_new_pred", 32'(PredTaken), 1);
    chk("alias_new_target", 32'(PredTarget), 32'h148);
    tick();

    IfPC = 9'h080;
    set_ex(1, 'h80, 1, 'h10, 0, 0, 0);
    settle();
    chk("collide_old_pred", 32'(PredTaken), 0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("collide_new_pred", 32'(PredTaken), 1);
    chk("collide_new_target", 32'(PredTarget), 32'h90);
    tick();

    reset = 1'b1;
    IfPC  = 9'h00C;
    set_ex(1, 'h0C, 1, 'h4, 0, 0, 0);
    settle();
    chk("rst_resolve_redirect", 32'(Redirect), 1);
    tick();
    reset = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rst_resolve_no_alloc", 32'(PredTaken), 0);
    chk("rst_resolve_br_count", 32'(BrCount), 0);
    chk("rst_resolve_misp_count", 32'(MispCount), 0);
    tick();
    IfPC = 9'h080;
    settle();
    chk("rst_table_cleared", 32'(PredTaken), 0);
    tick();

    for (int v = 0; v < 10; v++) begin
      set_ex(vecs[v].cls, vecs[v].pc, vecs[v].cond, vecs[v].imm, vecs[v].reg1,
             vecs[v].pt, vecs[v].ptgt);
      IfPC = 9'($urandom_range(0, 127) * 4);
      settle();
      chk("vec_redirect", 32'(Redirect), 32'(vecs[v].e_red));
      chk("vec_redirect_pc", RedirectPC, vecs[v].e_rpc);
      if (vecs[v].cls >= 1 && vecs[v].cls <= 3) chk("vec_pc_imm", PC_Imm, vecs[v].e_pcimm);
      tick();
    end

    for (int n = 0; n < 600; n++) begin
      int unsigned pc, imm, ptgt, ifpc;
      bit pt;
      reset = ($urandom_range(0, 199) == 0);
      pc    = $urandom_range(0, 7) * 4 + $urandom_range(0, 7) * 64;
      imm   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255)) - 32'd128;
      if ($urandom_range(0, 3) != 0) begin
        m_pred(pc, pt, ptgt);
      end else begin
        pt   = 1'($urandom_range(0, 1));
        ptgt = $urandom_range(0, 511);
      end
      set_ex($urandom_range(0, 4), pc, 1'($urandom_range(0, 1)), imm, $urandom(), pt, ptgt);
      ifpc = ($urandom_range(0, 1) == 0) ? pc : $urandom_range(0, 127) * 4;
      IfPC = ifpc[PC_W-1:0];
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
